// File: rtl/spart_tx_queue_if.sv
// Handshake bundle between the bus-side writer / SPART transmitter and the TX queue.
// Optional overflow ports exist only when SPART_TXQ_OVF_EN is defined.
interface spart_tx_queue_if #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 8
);
    logic                  wr_en;
    logic [DATA_W-1:0]     wr_data;
    logic                  flush;
    logic                  tx_started;
    logic                  queue_not_empty;
    logic [DATA_W-1:0]     tx_data;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
`ifdef SPART_TXQ_OVF_EN
    logic                  ovf;
    logic                  ovf_clr;

    modport master (
        output wr_en, wr_data, flush, tx_started, ovf_clr,
        input  queue_not_empty, tx_data, full, count, ovf
    );
    modport slave (
        input  wr_en, wr_data, flush, tx_started, ovf_clr,
        output queue_not_empty, tx_data, full, count, ovf
    );
`else
    modport master (
        output wr_en, wr_data, flush, tx_started,
        input  queue_not_empty, tx_data, full, count
    );
    modport slave (
        input  wr_en, wr_data, flush, tx_started,
        output queue_not_empty, tx_data, full, count
    );
`endif
endinterface

// File: rtl/spart_tx_queue.sv
// Circular TX FIFO feeding the SPART transmitter; head byte is read combinationally.
// Optional sticky overflow flag enabled by defining SPART_TXQ_OVF_EN.
module spart_tx_queue #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spart_tx_queue_if.slave   q
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  not_empty_r;
    logic                  full_r;
    logic                  pop;
    logic                  push;

    // A pop on an empty queue is ignored; a push into a full queue needs a simultaneous pop.
    assign pop  = q.tx_started && (count_r != '0);
    assign push = q.wr_en && (!full_r || pop);

    always_comb begin
        count_nxt = count_r;
        if (q.flush)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count_r + 1'b1;
        else if (pop && !push)
            count_nxt = count_r - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_r     <= '0;
            not_empty_r <= 1'b0;
            full_r      <= 1'b0;
        end else begin
            count_r     <= count_nxt;
            not_empty_r <= (count_nxt != '0);
            full_r      <= (count_nxt == FULL_CNT);
            if (q.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (push && !q.flush)
            mem[wr_ptr] <= q.wr_data;
    end

    assign q.tx_data         = mem[rd_ptr];
    assign q.queue_not_empty = not_empty_r;
    assign q.full            = full_r;
    assign q.count           = count_r;

`ifdef SPART_TXQ_OVF_EN
    logic ovf_r;

    // Clear wins over a coincident dropped push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_r <= 1'b0;
        else if (q.ovf_clr)
            ovf_r <= 1'b0;
        else if (q.wr_en && !push)
            ovf_r <= 1'b1;
    end

    assign q.ovf = ovf_r;
`endif

endmodule

// File: tb/tb_spart_tx_queue.sv
// Directed self-checking bench for spart_tx_queue (8-entry, 8-bit configuration).
module tb_spart_tx_queue;
    localparam int DEPTH_LOG2 = 3;
    localparam int DATA_W     = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    spart_tx_queue_if #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) qif ();

    spart_tx_queue #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (qif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        qif.wr_en      = 1'b0;
        qif.tx_started = 1'b0;
        qif.flush      = 1'b0;
`ifdef SPART_TXQ_OVF_EN
        qif.ovf_clr    = 1'b0;
`endif
    endtask

    logic [7:0] drain_exp [8];

    initial begin
        rst_n       = 1'b0;
        qif.wr_data = '0;
        idle();
        tick();
        tick();
        check("rst_count", 32'(qif.count), 0);
        check("rst_qne", 32'(qif.queue_not_empty), 0);
        check("rst_full", 32'(qif.full), 0);
        rst_n = 1'b1;
        tick();

        // Reset mid-traffic with five entries queued
        for (int i = 0; i < 5; i++) begin
            qif.wr_en = 1'b1; qif.wr_data = 8'(8'hC0 + i);
            tick();
        end
        idle();
        check("pre_rst_count", 32'(qif.count), 5);
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(qif.count), 0);
        check("async_rst_qne", 32'(qif.queue_not_empty), 0);
        check("async_rst_full", 32'(qif.full), 0);
`ifdef SPART_TXQ_OVF_EN
        check("async_rst_ovf", 32'(qif.ovf), 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // Ordering
        qif.wr_en = 1'b1; qif.wr_data = 8'h55; tick();
        check("ord_count1", 32'(qif.count), 1);
        check("ord_qne1", 32'(qif.queue_not_empty), 1);
        check("ord_head1", 32'(qif.tx_data), 32'h55);
        qif.wr_data = 8'hA3; tick();
        qif.wr_data = 8'h0F; tick();
        idle();
        check("ord_count3", 32'(qif.count), 3);
        check("ord_head_a", 32'(qif.tx_data), 32'h55);
        qif.tx_started = 1'b1; tick();
        check("ord_head_b", 32'(qif.tx_data), 32'hA3);
        check("ord_count2", 32'(qif.count), 2);
        tick();
        check("ord_head_c", 32'(qif.tx_data), 32'h0F);
        check("ord_qne_c", 32'(qif.queue_not_empty), 1);
        tick();
        check("ord_count0", 32'(qif.count), 0);
        check("ord_qne0", 32'(qif.queue_not_empty), 0);
        // Pop on empty queue must not underflow
        tick();
        idle();
        check("empty_pop_count", 32'(qif.count), 0);
        check("empty_pop_qne", 32'(qif.queue_not_empty), 0);

        // Fill and overflow
        for (int i = 0; i < 8; i++) begin
            qif.wr_en = 1'b1; qif.wr_data = 8'(8'h10 + i);
            tick();
            check("fill_count", 32'(qif.count), 32'(i + 1));
            check("fill_full", 32'(qif.full), (i == 7) ? 1 : 0);
        end
        qif.wr_data = 8'h99; tick();
        idle();
        check("drop_count", 32'(qif.count), 8);
        check("drop_full", 32'(qif.full), 1);
        check("drop_head", 32'(qif.tx_data), 32'h10);
`ifdef SPART_TXQ_OVF_EN
        check("ovf_set", 32'(qif.ovf), 1);
        tick();
        check("ovf_hold", 32'(qif.ovf), 1);
        qif.flush = 1'b0; qif.ovf_clr = 1'b1; qif.wr_en = 1'b1; qif.wr_data = 8'h98;
        tick();
        idle();
        check("ovf_clr_prio", 32'(qif.ovf), 0);
        check("ovf_clr_count", 32'(qif.count), 8);
`endif

        // Push+pop while full
        qif.wr_en = 1'b1; qif.wr_data = 8'hEE; qif.tx_started = 1'b1;
        tick();
        idle();
        check("full_pp_count", 32'(qif.count), 8);
        check("full_pp_full", 32'(qif.full), 1);
        check("full_pp_head", 32'(qif.tx_data), 32'h11);
        for (int i = 0; i < 7; i++) drain_exp[i] = 8'(8'h11 + i);
        drain_exp[7] = 8'hEE;
        for (int i = 0; i < 8; i++) begin
            check("drain_head", 32'(qif.tx_data), 32'(drain_exp[i]));
            qif.tx_started = 1'b1;
            tick();
            check("drain_count", 32'(qif.count), 32'(7 - i));
        end
        idle();
        check("drain_qne", 32'(qif.queue_not_empty), 0);
        check("drain_full", 32'(qif.full), 0);

        // Push+pop on an empty queue keeps the push
        qif.wr_en = 1'b1; qif.wr_data = 8'h77; qif.tx_started = 1'b1;
        tick();
        idle();
        check("empty_pp_count", 32'(qif.count), 1);
        check("empty_pp_qne", 32'(qif.queue_not_empty), 1);
        check("empty_pp_head", 32'(qif.tx_data), 32'h77);
        qif.tx_started = 1'b1; tick(); idle();
        check("empty_pp_pop", 32'(qif.count), 0);

        // Streaming across pointer wrap with count held at 1
        for (int i = 0; i < 20; i++) begin
            if (i > 0) check("wrap_head", 32'(qif.tx_data), 32'(i - 1));
            qif.wr_en = 1'b1; qif.wr_data = 8'(i); qif.tx_started = (i > 0);
            tick();
            check("wrap_count", 32'(qif.count), 1);
        end
        idle();
        check("wrap_last", 32'(qif.tx_data), 32'h13);
        qif.tx_started = 1'b1; tick(); idle();
        check("wrap_empty", 32'(qif.count), 0);

        // Flush overrides a coincident push
        for (int i = 0; i < 3; i++) begin
            qif.wr_en = 1'b1; qif.wr_data = 8'(8'h30 + i);
            tick();
        end
        qif.flush = 1'b1; qif.wr_data = 8'h3F;
        tick();
        idle();
        check("flush_count", 32'(qif.count), 0);
        check("flush_qne", 32'(qif.queue_not_empty), 0);
        qif.wr_en = 1'b1; qif.wr_data = 8'hAB; tick(); idle();
        check("post_flush_head", 32'(qif.tx_data), 32'hAB);
        check("post_flush_count", 32'(qif.count), 1);

`ifdef SPART_TXQ_OVF_EN
        // Flush leaves a set overflow flag alone
        for (int i = 0; i < 8; i++) begin
            qif.wr_en = 1'b1; qif.wr_data = 8'(i); tick();
        end
        idle();
        check("ovf_refill_set", 32'(qif.ovf), 1);
        qif.flush = 1'b1; tick(); idle();
        check("ovf_after_flush", 32'(qif.ovf), 1);
        check("ovf_flush_count", 32'(qif.count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
